// File: rtl/pool_window_reader_pkg.sv
// pool_window_reader_pkg: shared state encoding, window element slots and width helper
package pool_window_reader_pkg;
  typedef enum logic [2:0] {S_IDLE, S_TOP, S_BOT, S_LAST, S_OUT, S_DONE} state_t;
  localparam int TL = 0;
  localparam int TR = 1;
  localparam int BL = 2;
  localparam int BR = 3;
  function automatic int idx_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/pool_window_reader_if.sv
// pool_window_reader_if: memory read ports, window output and valid/ready handshake
interface pool_window_reader_if
  import pool_window_reader_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int IFM_SIZE         = 16,
  parameter int ADDRESS_SIZE_IFM = $clog2(IFM_SIZE * IFM_SIZE),
  parameter int OFM_SIZE         = IFM_SIZE / 2
);
  localparam int OW = idx_width(OFM_SIZE);
  logic                        start;
  logic [ADDRESS_SIZE_IFM-1:0] Address_A;
  logic [ADDRESS_SIZE_IFM-1:0] Address_B;
  logic                        Enable_Read_A_Mem;
  logic                        Enable_Read_B_Mem;
  logic [DATA_WIDTH-1:0]       Data_Output_A_Mem1;
  logic [DATA_WIDTH-1:0]       Data_Output_B_Mem1;
  logic [DATA_WIDTH-1:0]       Data_Output_A_Mem2;
  logic [DATA_WIDTH-1:0]       Data_Output_B_Mem2;
  logic [4*DATA_WIDTH-1:0]     Window_Mem1;
  logic [4*DATA_WIDTH-1:0]     Window_Mem2;
  logic [OW-1:0]               OFM_Row;
  logic [OW-1:0]               OFM_Col;
  logic                        window_valid;
  logic                        window_ready;
  logic                        busy;
  logic                        done;
  modport master (
    input  start, Data_Output_A_Mem1, Data_Output_B_Mem1, Data_Output_A_Mem2,
           Data_Output_B_Mem2, window_ready,
    output Address_A, Address_B, Enable_Read_A_Mem, Enable_Read_B_Mem, Window_Mem1,
           Window_Mem2, OFM_Row, OFM_Col, window_valid, busy, done
  );
  modport slave (
    output start, Data_Output_A_Mem1, Data_Output_B_Mem1, Data_Output_A_Mem2,
           Data_Output_B_Mem2, window_ready,
    input  Address_A, Address_B, Enable_Read_A_Mem, Enable_Read_B_Mem, Window_Mem1,
           Window_Mem2, OFM_Row, OFM_Col, window_valid, busy, done
  );
endinterface

// File: rtl/pool_window_addr_gen.sv
// pool_window_addr_gen: raster r/c window counters and top/bottom row base addresses
module pool_window_addr_gen
  import pool_window_reader_pkg::*;
#(
  parameter  int IFM_SIZE         = 16,
  parameter  int ADDRESS_SIZE_IFM = $clog2(IFM_SIZE * IFM_SIZE),
  parameter  int OFM_SIZE         = IFM_SIZE / 2,
  localparam int OW               = idx_width(OFM_SIZE)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        advance_i,
  input  logic                        clear_i,
  output logic [ADDRESS_SIZE_IFM-1:0] top_addr_o,
  output logic [ADDRESS_SIZE_IFM-1:0] bot_addr_o,
  output logic                        last_o,
  output logic [OW-1:0]               row_o,
  output logic [OW-1:0]               col_o
);
  localparam logic [ADDRESS_SIZE_IFM-1:0] IFM_A = ADDRESS_SIZE_IFM'(IFM_SIZE);
  logic [OW-1:0] r_q, r_d, c_q, c_d;
  logic          c_last;
  assign c_last = c_q == OW'(OFM_SIZE - 1);
  assign last_o = c_last && r_q == OW'(OFM_SIZE - 1);
  always_comb begin
    c_d = clear_i ? '0 : advance_i ? (c_last ? '0 : c_q + 1'b1) : c_q;
    r_d = clear_i ? '0 : (advance_i && c_last) ? r_q + 1'b1 : r_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q <= '0;
      c_q <= '0;
    end else begin
      r_q <= r_d;
      c_q <= c_d;
    end
  end
  // window origin is (2r, 2c); the bottom row sits one map row below
  assign top_addr_o = ADDRESS_SIZE_IFM'({r_q, 1'b0}) * IFM_A + ADDRESS_SIZE_IFM'({c_q, 1'b0});
  assign bot_addr_o = top_addr_o + IFM_A;
  assign row_o      = r_q;
  assign col_o      = c_q;
endmodule

// File: rtl/pool_window_reader.sv
// pool_window_reader: fetches 2x2 windows from paired dual-port memories for max-pooling
module pool_window_reader
  import pool_window_reader_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int IFM_SIZE         = 16,
  parameter int ADDRESS_SIZE_IFM = $clog2(IFM_SIZE * IFM_SIZE),
  parameter int OFM_SIZE         = IFM_SIZE / 2
) (
  input logic                 clk,
  input logic                 reset,
  pool_window_reader_if.master bus
);
  localparam int OW = idx_width(OFM_SIZE);
  state_t                        state_q, state_d;
  logic [3:0][DATA_WIDTH-1:0]    win1_q, win1_d, win2_q, win2_d;
  logic [ADDRESS_SIZE_IFM-1:0]   top_addr, bot_addr, addr_a;
  logic [OW-1:0]                 row, col;
  logic                          last, advance, clear, rd;
  pool_window_addr_gen #(
    .IFM_SIZE        (IFM_SIZE),
    .ADDRESS_SIZE_IFM(ADDRESS_SIZE_IFM),
    .OFM_SIZE        (OFM_SIZE)
  ) u_addr (
    .clk       (clk),
    .reset     (reset),
    .advance_i (advance),
    .clear_i   (clear),
    .top_addr_o(top_addr),
    .bot_addr_o(bot_addr),
    .last_o    (last),
    .row_o     (row),
    .col_o     (col)
  );
  always_comb begin
    state_d = state_q;
    advance = 1'b0;
    clear   = 1'b0;
    unique case (state_q)
      S_IDLE: state_d = bus.start ? S_TOP : S_IDLE;
      S_TOP:  state_d = S_BOT;
      S_BOT:  state_d = S_LAST;
      S_LAST: state_d = S_OUT;
      S_OUT: begin
        state_d = bus.window_ready ? (last ? S_DONE : S_TOP) : S_OUT;
        advance = bus.window_ready && !last;
      end
      S_DONE: begin
        state_d = S_IDLE;
        clear   = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // read data lags the enable by one cycle: top row lands in BOT, bottom row in LAST
  always_comb begin
    win1_d = win1_q;
    win2_d = win2_q;
    if (state_q == S_BOT) begin
      win1_d[TL] = bus.Data_Output_A_Mem1;
      win1_d[TR] = bus.Data_Output_B_Mem1;
      win2_d[TL] = bus.Data_Output_A_Mem2;
      win2_d[TR] = bus.Data_Output_B_Mem2;
    end
    if (state_q == S_LAST) begin
      win1_d[BL] = bus.Data_Output_A_Mem1;
      win1_d[BR] = bus.Data_Output_B_Mem1;
      win2_d[BL] = bus.Data_Output_A_Mem2;
      win2_d[BR] = bus.Data_Output_B_Mem2;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      win1_q  <= '0;
      win2_q  <= '0;
    end else begin
      state_q <= state_d;
      win1_q  <= win1_d;
      win2_q  <= win2_d;
    end
  end
  assign rd                    = state_q == S_TOP || state_q == S_BOT;
  assign addr_a                = state_q == S_TOP ? top_addr : state_q == S_BOT ? bot_addr : '0;
  assign bus.Address_A         = addr_a;
  assign bus.Address_B         = rd ? addr_a + 1'b1 : '0;
  assign bus.Enable_Read_A_Mem = rd;
  assign bus.Enable_Read_B_Mem = rd;
  assign bus.Window_Mem1       = win1_q;
  assign bus.Window_Mem2       = win2_q;
  assign bus.OFM_Row           = row;
  assign bus.OFM_Col           = col;
  assign bus.window_valid      = state_q == S_OUT;
  assign bus.busy              = state_q != S_IDLE;
  assign bus.done              = state_q == S_DONE;
endmodule

// File: tb/tb_pool_window_reader.sv
// tb_pool_window_reader: scoreboard bench for IFM_SIZE=4 and IFM_SIZE=5 instances
module tb_pool_window_reader;
  localparam int DW = 32;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int           r;
    int           c;
    logic [127:0] w1;
    logic [127:0] w2;
  } exp_t;
  exp_t q4[$];
  exp_t q5[$];
  int t4[4][4] = '{'{0, 1, 4, 5}, '{2, 3, 6, 7}, '{8, 9, 12, 13}, '{10, 11, 14, 15}};
  int t5[4][4] = '{'{0, 1, 5, 6}, '{2, 3, 7, 8}, '{10, 11, 15, 16}, '{12, 13, 17, 18}};

  pool_window_reader_if #(.DATA_WIDTH(DW), .IFM_SIZE(4)) b4 ();
  pool_window_reader_if #(.DATA_WIDTH(DW), .IFM_SIZE(5)) b5 ();
  pool_window_reader #(.DATA_WIDTH(DW), .IFM_SIZE(4)) u4 (.clk(clk), .reset(reset), .bus(b4.master));
  pool_window_reader #(.DATA_WIDTH(DW), .IFM_SIZE(5)) u5 (.clk(clk), .reset(reset), .bus(b5.master));

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] win(input int tl, input int tr, input int bl, input int br, input int off);
    return {32'(br + off), 32'(bl + off), 32'(tr + off), 32'(tl + off)};
  endfunction

  // memory models: mem1[a]=a, mem2[a]=100+a, one-cycle registered read
  always @(posedge clk) begin
    if (b4.Enable_Read_A_Mem) begin
      b4.Data_Output_A_Mem1 <= 32'(b4.Address_A);
      b4.Data_Output_A_Mem2 <= 32'(b4.Address_A) + 32'd100;
    end
    if (b4.Enable_Read_B_Mem) begin
      b4.Data_Output_B_Mem1 <= 32'(b4.Address_B);
      b4.Data_Output_B_Mem2 <= 32'(b4.Address_B) + 32'd100;
    end
    if (b5.Enable_Read_A_Mem) begin
      b5.Data_Output_A_Mem1 <= 32'(b5.Address_A);
      b5.Data_Output_A_Mem2 <= 32'(b5.Address_A) + 32'd100;
    end
    if (b5.Enable_Read_B_Mem) begin
      b5.Data_Output_B_Mem1 <= 32'(b5.Address_B);
      b5.Data_Output_B_Mem2 <= 32'(b5.Address_B) + 32'd100;
    end
  end

  // monitors: compare presented windows against the queue head, pop on handshake
  always begin
    @(negedge clk);
    #1;
    if (b4.window_valid) begin
      if (q4.size() == 0) chk("u4_unexpected_window", b4.window_valid, 1'b0);
      else begin
        chk("u4_win1", b4.Window_Mem1, q4[0].w1);
        chk("u4_win2", b4.Window_Mem2, q4[0].w2);
        chk("u4_row", b4.OFM_Row, q4[0].r);
        chk("u4_col", b4.OFM_Col, q4[0].c);
        if (b4.window_ready) void'(q4.pop_front());
      end
    end
    if (b5.window_valid) begin
      if (q5.size() == 0) chk("u5_unexpected_window", b5.window_valid, 1'b0);
      else begin
        chk("u5_win1", b5.Window_Mem1, q5[0].w1);
        chk("u5_win2", b5.Window_Mem2, q5[0].w2);
        chk("u5_row", b5.OFM_Row, q5[0].r);
        chk("u5_col", b5.OFM_Col, q5[0].c);
        if (b5.window_ready) void'(q5.pop_front());
      end
    end
    if (b4.Enable_Read_A_Mem || b4.Enable_Read_B_Mem) begin
      chk("u4_en_pair", b4.Enable_Read_B_Mem, b4.Enable_Read_A_Mem);
      chk("u4_addr_b", b4.Address_B, 32'(b4.Address_A) + 1);
    end else chk("u4_addr_idle", {b4.Address_A, b4.Address_B}, 0);
    if (b5.Enable_Read_A_Mem) begin
      chk("u5_addr_b", b5.Address_B, 32'(b5.Address_A) + 1);
      chk("u5_no_addr24", b5.Address_A == 5'd24 || b5.Address_B == 5'd24, 1'b0);
    end
  end

  task automatic push4(input int n);
    for (int i = 0; i < n; i++)
      q4.push_back('{r: i / 2, c: i % 2, w1: win(t4[i][0], t4[i][1], t4[i][2], t4[i][3], 0),
                     w2: win(t4[i][0], t4[i][1], t4[i][2], t4[i][3], 100)});
  endtask

  // mode 0: plain, 1: stall on (0,1), 2: extra start pulses mid-scan and on done
  task automatic run_scan4(input int mode, input int exp_done);
    int first_v = -1;
    int done_cyc = -1;
    int done_cnt = 0;
    int stall = 0;
    push4(4);
    @(negedge clk);
    b4.start = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      b4.start = (mode == 2 && k == 6);
      if (mode == 1 && b4.window_valid && b4.OFM_Row == 1'b0 && b4.OFM_Col == 1'b1 && stall < 5) begin
        b4.window_ready = 1'b0;
        stall++;
        chk("stall_no_read", {b4.Enable_Read_A_Mem, b4.Enable_Read_B_Mem}, 0);
      end else b4.window_ready = 1'b1;
      if (mode == 0) chk("en_schedule", b4.Enable_Read_A_Mem, k <= 16 && (k - 1) % 4 < 2);
      if (b4.window_valid && first_v < 0) first_v = k;
      if (b4.done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = k;
        if (mode == 2) b4.start = 1'b1;
      end
    end
    chk("first_valid_cycle", first_v, 4);
    chk("done_cycle", done_cyc, exp_done);
    chk("done_count", done_cnt, 1);
    chk("queue_drained", q4.size(), 0);
    chk("idle_after_scan", b4.busy, 1'b0);
  endtask

  task automatic abort4();
    push4(2);
    @(negedge clk);
    b4.start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      b4.start = 1'b0;
    end
    chk("abort_bot_en", b4.Enable_Read_A_Mem, 1'b1);
    chk("abort_bot_addr", b4.Address_A, 12);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #2;
      chk("abort_outputs_zero", |{b4.Address_A, b4.Address_B, b4.Enable_Read_A_Mem, b4.Enable_Read_B_Mem,
          b4.Window_Mem1, b4.Window_Mem2, b4.OFM_Row, b4.OFM_Col, b4.window_valid, b4.busy, b4.done}, 1'b0);
    end
    chk("abort_queue", q4.size(), 0);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("abort_no_done", b4.done, 1'b0);
    end
  endtask

  task automatic run_scan5();
    int done_cyc = -1;
    for (int i = 0; i < 4; i++)
      q5.push_back('{r: i / 2, c: i % 2, w1: win(t5[i][0], t5[i][1], t5[i][2], t5[i][3], 0),
                     w2: win(t5[i][0], t5[i][1], t5[i][2], t5[i][3], 100)});
    @(negedge clk);
    b5.start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      b5.start = 1'b0;
      if (b5.done && done_cyc < 0) done_cyc = k;
    end
    chk("u5_done_cycle", done_cyc, 17);
    chk("u5_queue_drained", q5.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    b4.start = 1'b0;
    b5.start = 1'b0;
    b4.window_ready = 1'b1;
    b5.window_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("u4_reset_outputs", |{b4.Address_A, b4.Address_B, b4.Enable_Read_A_Mem, b4.Enable_Read_B_Mem,
        b4.Window_Mem1, b4.Window_Mem2, b4.OFM_Row, b4.OFM_Col, b4.window_valid, b4.busy, b4.done}, 1'b0);
    chk("u5_reset_outputs", |{b5.Address_A, b5.Enable_Read_A_Mem, b5.Window_Mem1, b5.window_valid,
        b5.busy, b5.done}, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    run_scan4(0, 17);
    run_scan4(1, 22);
    run_scan4(2, 17);
    abort4();
    run_scan4(0, 17);
    run_scan5();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
